// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle controller.
// States, ALU codes, opcode classes and datapath mux selects.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_UNKNOWN
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_UND = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation and flag-write decode for data-processing instructions.
// nowrite flags CMP so the following writeback can be suppressed.
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] Funct,
  input  logic       enable,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW,
  output logic       nowrite
);

  logic arith;
  logic known;

  always_comb begin
    ALUControl = ALU_ADD;
    arith      = 1'b0;
    known      = 1'b0;
    nowrite    = 1'b0;
    if (enable) begin
      known = 1'b1;
      case (Funct[4:1])
        CMD_ADD: begin
          ALUControl = ALU_ADD;
          arith      = 1'b1;
        end
        CMD_SUB: begin
          ALUControl = ALU_SUB;
          arith      = 1'b1;
        end
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        CMD_CMP: begin
          ALUControl = ALU_SUB;
          arith      = 1'b1;
          nowrite    = 1'b1;
        end
        default: known = 1'b0;
      endcase
    end
  end

  // Unsupported commands never touch the flags
  assign FlagW[1] = known & Funct[0];
  assign FlagW[0] = known & Funct[0] & arith;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main controller: Moore FSM sequencing fetch, decode,
// memory, data-processing and branch steps for one instruction.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       InstrDone,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  localparam logic [STATE_W-1:0] FETCH   = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] DECODE  = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] MEMADR  = STATE_W'(S_MEMADR);
  localparam logic [STATE_W-1:0] MEMRD   = STATE_W'(S_MEMRD);
  localparam logic [STATE_W-1:0] MEMWB   = STATE_W'(S_MEMWB);
  localparam logic [STATE_W-1:0] MEMWR   = STATE_W'(S_MEMWR);
  localparam logic [STATE_W-1:0] EXECR   = STATE_W'(S_EXECR);
  localparam logic [STATE_W-1:0] EXECI   = STATE_W'(S_EXECI);
  localparam logic [STATE_W-1:0] ALUWB   = STATE_W'(S_ALUWB);
  localparam logic [STATE_W-1:0] BRANCH  = STATE_W'(S_BRANCH);
  localparam logic [STATE_W-1:0] UNKNOWN = STATE_W'(S_UNKNOWN);

  logic [STATE_W-1:0] state_q, state_d;
  logic nowrite_q, nowrite_d;
  logic alu_en;
  logic dec_nowrite;
  logic reg_w;
  logic branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      nowrite_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      nowrite_q <= nowrite_d;
    end
  end

  alu_decoder u_alu_dec (
    .Funct      (Funct),
    .enable     (alu_en),
    .ALUControl (ALUControl),
    .FlagW      (FlagW),
    .nowrite    (dec_nowrite)
  );

  always_comb begin
    state_d   = FETCH;
    nowrite_d = nowrite_q;
    NextPC    = 1'b0;
    MemW      = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    InstrDone = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcB   = SRCB_REG;
    alu_en    = 1'b0;
    reg_w     = 1'b0;
    branch    = 1'b0;
    case (state_q)
      FETCH: begin
        state_d   = DECODE;
        nowrite_d = 1'b0;
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        case (Op)
          OP_MEM:  state_d = MEMADR;
          OP_DP:   state_d = Funct[5] ? EXECI : EXECR;
          OP_BR:   state_d = BRANCH;
          default: state_d = UNKNOWN;
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
        InstrDone = 1'b1;
      end
      MEMWR: begin
        AdrSrc    = 1'b1;
        MemW      = 1'b1;
        InstrDone = 1'b1;
      end
      EXECR: begin
        ALUSrcB   = SRCB_REG;
        alu_en    = 1'b1;
        nowrite_d = dec_nowrite;
        state_d   = ALUWB;
      end
      EXECI: begin
        ALUSrcB   = SRCB_IMM;
        alu_en    = 1'b1;
        nowrite_d = dec_nowrite;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_w     = ~nowrite_q;
        InstrDone = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        branch    = 1'b1;
        InstrDone = 1'b1;
      end
      // UNKNOWN and illegal encodings: no strobes, back to fetch
      default: InstrDone = 1'b1;
    endcase
  end

  assign RegW      = reg_w;
  assign PCS       = branch | (reg_w & (Rd == 4'hF));
  assign ImmSrc    = Op;
  assign RegSrc[0] = (Op == OP_BR);
  assign RegSrc[1] = (Op == OP_MEM);

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: instruction vector table expanded into per-cycle
// expected outputs on a scoreboard queue, plus reset corner cases.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, InstrDone;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW;

  typedef struct packed {
    logic       pcs;
    logic       nextpc;
    logic       regw;
    logic       memw;
    logic       irwrite;
    logic       adrsrc;
    logic       alusrca;
    logic       done;
    logic [1:0] ressrc;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [1:0] regsrc;
    logic [1:0] aluctl;
    logic [1:0] flagw;
  } o_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    int         ncyc;
    logic [1:0] alu;
    logic [1:0] flw;
    bit         cmp;
  } vec_t;

  vec_t vecs[12];
  o_t   sb[$];
  int   checks = 0;
  int   errors = 0;

  multicycle_control #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Op         (Op),
    .Funct      (Funct),
    .Rd         (Rd),
    .PCS        (PCS),
    .NextPC     (NextPC),
    .RegW       (RegW),
    .MemW       (MemW),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .InstrDone  (InstrDone),
    .ResultSrc  (ResultSrc),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .FlagW      (FlagW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic o_t actual();
    o_t a;
    a = '{PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, InstrDone,
          ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW};
    return a;
  endfunction

  task automatic check_o(input string nm, input o_t exp);
    o_t a;
    a = actual();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, a, exp);
    end
  endtask

  task automatic check_b(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  // Expected outputs of cycle 'step' (0 = FETCH) for instruction v
  function automatic o_t model(input vec_t v, input int step);
    o_t e;
    e = '0;
    e.immsrc = v.op;
    e.regsrc = {v.op == 2'b01, v.op == 2'b10};
    if (step == 0) begin
      e.irwrite = 1; e.nextpc = 1; e.alusrca = 1;
      e.alusrcb = 2'b10; e.ressrc = 2'b10;
    end else if (step == 1) begin
      e.alusrca = 1; e.alusrcb = 2'b10; e.ressrc = 2'b10;
    end else begin
      case (v.op)
        2'b00:
          if (step == 2) begin
            e.alusrcb = v.funct[5] ? 2'b01 : 2'b00;
            e.aluctl = v.alu;
            e.flagw = v.flw;
          end else begin
            e.regw = !v.cmp;
            e.pcs = !v.cmp && v.rd == 4'hF;
            e.done = 1;
          end
        2'b01:
          if (step == 2) e.alusrcb = 2'b01;
          else if (v.funct[0] && step == 3) e.adrsrc = 1;
          else if (v.funct[0]) begin
            e.ressrc = 2'b01; e.regw = 1; e.done = 1;
            e.pcs = v.rd == 4'hF;
          end else begin
            e.adrsrc = 1; e.memw = 1; e.done = 1;
          end
        2'b10: begin
          e.alusrcb = 2'b01; e.ressrc = 2'b10; e.pcs = 1; e.done = 1;
        end
        default: e.done = 1;
      endcase
    end
    return e;
  endfunction

  task automatic run_vec(input int idx);
    o_t e;
    int step;
    Op = vecs[idx].op;
    Funct = vecs[idx].funct;
    Rd = vecs[idx].rd;
    for (int s = 0; s < vecs[idx].ncyc; s++) sb.push_back(model(vecs[idx], s));
    step = 0;
    while (sb.size() > 0) begin
      #1;
      e = sb.pop_front();
      check_o($sformatf("vec%0d_cyc%0d", idx, step), e);
      step++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0]  = '{2'b00, 6'b001000, 4'd1,  4, 2'b00, 2'b00, 0}; // ADD
    vecs[1]  = '{2'b00, 6'b100101, 4'd0,  4, 2'b01, 2'b11, 0}; // SUBS #imm
    vecs[2]  = '{2'b00, 6'b010101, 4'd0,  4, 2'b01, 2'b11, 1}; // CMP
    vecs[3]  = '{2'b00, 6'b000001, 4'd2,  4, 2'b10, 2'b10, 0}; // ANDS
    vecs[4]  = '{2'b00, 6'b111000, 4'd3,  4, 2'b11, 2'b00, 0}; // ORR #imm
    vecs[5]  = '{2'b00, 6'b000011, 4'd4,  4, 2'b00, 2'b00, 0}; // EORS unsupported
    vecs[6]  = '{2'b00, 6'b001000, 4'd15, 4, 2'b00, 2'b00, 0}; // ADD PC
    vecs[7]  = '{2'b01, 6'b011001, 4'd4,  5, 2'b00, 2'b00, 0}; // LDR
    vecs[8]  = '{2'b01, 6'b011001, 4'd15, 5, 2'b00, 2'b00, 0}; // LDR PC
    vecs[9]  = '{2'b01, 6'b011000, 4'd5,  4, 2'b00, 2'b00, 0}; // STR
    vecs[10] = '{2'b10, 6'b000000, 4'd0,  3, 2'b00, 2'b00, 0}; // B
    vecs[11] = '{2'b11, 6'b101011, 4'd15, 3, 2'b00, 2'b00, 0}; // undefined

    rst_n = 1'b0;
    Op = 2'b00; Funct = 6'b001000; Rd = 4'd1;
    #3;
    check_o("reset_fetch", model(vecs[0], 0));
    #9;
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i);

    // Reset dropped while in MEMWR
    Op = 2'b01; Funct = 6'b011000; Rd = 4'd5;
    #1;
    check_b("str_fetch_irw", IRWrite, 1'b1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #1;
    check_b("memwr_memw", MemW, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_b("rst_memw_fall", MemW, 1'b0);
    check_b("rst_fetch_irw", IRWrite, 1'b1);
    @(posedge clk);
    #1;
    check_b("rst_hold_regw", RegW, 1'b0);
    check_b("rst_hold_memw", MemW, 1'b0);
    check_b("rst_hold_irw", IRWrite, 1'b1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_b("post_rst_decode_irw", IRWrite, 1'b0);
    check_b("post_rst_decode_srca", ALUSrcA, 1'b1);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;

    // CMP then ADD: suppression must not leak past FETCH
    run_vec(2);
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter STATE_W, default 4, giving the state register width; it SHALL accommodate 11 states.
REQ-002 SHALL have port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port Op  input  2  instruction bits [27:26].
REQ-005 SHALL have port Funct  input  6  instruction bits [25:20] (I, cmd[3:0], S/L).
REQ-006 SHALL have port Rd  input  4  destination register field.
REQ-007 SHALL have outputs PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA, InstrDone, each 1 bit.
REQ-008 SHALL have outputs ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl, FlagW, each 2 bits.
REQ-009 SHALL deliver PCS, RegW, MemW and FlagW to the downstream condition-check stage; that stage gates them with CondEx. NextPC and IRWrite bypass that gating.

Function
REQ-010 SHALL implement the Moore FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH and UNKNOWN.
REQ-011 Transitions SHALL be:
- FETCH->DECODE.
- DECODE->MEMADR if Op=01.
- DECODE->EXECR if Op=00 and Funct[5]=0.
- DECODE->EXECI if Op=00 and Funct[5]=1.
- DECODE->BRANCH if Op=10.
- DECODE->UNKNOWN if Op=11.
REQ-012 Further transitions SHALL be:
- MEMADR->MEMRD if Funct[0]=1, else MEMWR.
- MEMRD->MEMWB.
- EXECR and EXECI->ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN->FETCH.
REQ-013 Per-state outputs SHALL be as follows; every unlisted output is 0:
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECR: ALUSrcB=00, ALU op decode enabled.
- EXECI: ALUSrcB=01, ALU op decode enabled.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, branch=1.
REQ-014 PCS SHALL equal branch OR (RegW AND Rd=1111).
REQ-015 When ALU op decode is enabled, ALUControl SHALL decode Funct[4:1] as ADD 0100->00, SUB 0010->01, AND 0000->10, ORR 1100->11, CMP 1010->01.
REQ-016 When ALU op decode is enabled and Funct[4:1] is any other code, ALUControl SHALL be 00 and FlagW SHALL be 00.
REQ-017 When ALU op decode is disabled, ALUControl SHALL be 00.
REQ-018 FlagW[1] SHALL equal Funct[0], and FlagW[0] SHALL equal Funct[0] AND (ADD, SUB or CMP); both are gated to EXECR/EXECI only, so flags update exactly once per data-processing instruction.
REQ-019 CMP SHALL suppress RegW in the ALUWB that follows it; a latched nowrite bit, captured in EXECR/EXECI, SHALL be held until FETCH.
REQ-020 ImmSrc SHALL equal Op; RegSrc[0] SHALL equal (Op=10); RegSrc[1] SHALL equal (Op=01); both are combinational and state-independent.
REQ-021 InstrDone SHALL be a 1-cycle pulse in MEMWB, MEMWR, ALUWB, BRANCH and UNKNOWN.
REQ-022 Latency SHALL be: LDR 5 cycles, STR 4, data-processing 4, B 3, undefined 3 (counted FETCH to FETCH).
REQ-023 Op/Funct/Rd SHALL be sampled only for next-state and output decisions; the block SHALL NOT register the instruction.
REQ-024 UNKNOWN SHALL assert no write strobe (RegW, MemW, PCS, FlagW, IRWrite all 0).
REQ-025 An illegal state encoding SHALL transition to FETCH next cycle, with all outputs as UNKNOWN.

Reset
REQ-026 rst_n low SHALL force state=FETCH and nowrite=0 asynchronously; FETCH outputs SHALL appear while in reset.
REQ-027 Reset asserted mid-instruction SHALL abandon the instruction with no RegW/MemW pulse after assertion.
REQ-028 After rst_n rises, the first rising clk edge SHALL move FETCH->DECODE.

Structure
REQ-029 A shared package SHALL hold the state enum, the ALUControl codes, the Op codes (DP=00, MEM=01, BR=10) and the ResultSrc/ALUSrcB encodings.
REQ-030 ALU/flag decoding SHALL be a sub-module alu_decoder (inputs Funct and enable; outputs ALUControl, FlagW and nowrite).

Verification
REQ-031 Scenario ADD R1,R2,R3 (Op=00, Funct=001000, Rd=0001) -> states FETCH, DECODE, EXECR, ALUWB; ALUControl=00 and FlagW=00 in EXECR; RegW=1 in ALUWB only.
REQ-032 Scenario SUBS R0,#imm (Funct=100101) -> EXECI; ALUControl=01 and FlagW=11 for exactly one cycle.
REQ-033 Scenario CMP (Funct=010101) -> FlagW=11 in EXEC; RegW=0 in ALUWB; InstrDone=1.
REQ-034 Scenario LDR (Op=01, Funct[0]=1) -> 5-state sequence; MEMRD AdrSrc=1; MEMWB ResultSrc=01, RegW=1. STR (Funct[0]=0) -> MemW=1 in MEMWR, 4 cycles.
REQ-035 Scenario B (Op=10) -> BRANCH with PCS=1 and ResultSrc=10. ADD with Rd=1111 -> PCS=1 in ALUWB.
REQ-036 Scenario rst_n dropped asynchronously in MEMWR -> MemW falls immediately and state=FETCH. Op=11 -> UNKNOWN with no write strobes.
